// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and data access.
// Define MEM_PORT_ARBITER_PERF_EN to add the saturating grant/stall performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 3
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              halt,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              idle
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [15:0]       perf_f_grants,
    output logic [15:0]       perf_d_grants,
    output logic [15:0]       perf_f_stall
`endif
);

    localparam int                    STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [1:0]            LAT_LAST   = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [1:0]          r_wait_cnt;
    logic [STREAK_W-1:0] r_d_streak;
    logic                r_gnt_d;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_f_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    state_t              w_next_state;
    logic                w_f_elig;
    logic                w_d_elig;
    logic                w_grant_f;
    logic                w_grant_d;
    logic                w_last_wait;
    logic [STREAK_W-1:0] w_next_streak;

    assign w_f_elig    = f_req & ~halt;
    assign w_d_elig    = d_req;
    assign w_last_wait = (r_state == S_WAIT) && (r_wait_cnt == LAT_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state  = r_state;
        w_grant_f     = 1'b0;
        w_grant_d     = 1'b0;
        w_next_streak = r_d_streak;
        case (r_state)
            S_IDLE: begin
                // Data wins ties until it has taken MAX_D_STREAK grants past a waiting fetch.
                if (w_d_elig && !(w_f_elig && (r_d_streak == STREAK_MAX))) begin
                    w_grant_d = 1'b1;
                    if (!w_f_elig)
                        w_next_streak = '0;
                    else if (r_d_streak != STREAK_MAX)
                        w_next_streak = r_d_streak + STREAK_W'(1);
                end else if (w_f_elig) begin
                    w_grant_f     = 1'b1;
                    w_next_streak = '0;
                end
                if (w_grant_f || w_grant_d)
                    w_next_state = S_ISSUE;
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (w_last_wait) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_d_streak  <= '0;
            r_gnt_d     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_d_streak <= w_next_streak;
            if (w_grant_f || w_grant_d) begin
                r_gnt_d    <= w_grant_d;
                r_mem_we   <= w_grant_d & d_we;
                r_mem_addr <= w_grant_d ? d_addr : f_addr;
                if (w_grant_d)
                    r_mem_wdata <= d_wdata;
            end
            if (r_state == S_ISSUE)
                r_wait_cnt <= '0;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + 2'd1;
            if (w_last_wait) begin
                if (!r_gnt_d)
                    r_f_rdata <= mem_rdata;
                else if (!r_mem_we)
                    r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign f_ack     = (r_state == S_RESP) && !r_gnt_d;
    assign d_ack     = (r_state == S_RESP) && r_gnt_d;
    assign f_rdata   = r_f_rdata;
    assign d_rdata   = r_d_rdata;
    assign idle      = (r_state == S_IDLE);

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [15:0] r_perf_f;
    logic [15:0] r_perf_d;
    logic [15:0] r_perf_stall;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_perf_f     <= '0;
            r_perf_d     <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_grant_f && (r_perf_f != 16'hFFFF))
                r_perf_f <= r_perf_f + 16'd1;
            if (w_grant_d && (r_perf_d != 16'hFFFF))
                r_perf_d <= r_perf_d + 16'd1;
            if (f_req && !f_ack && (r_perf_stall != 16'hFFFF))
                r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign perf_f_grants = r_perf_f;
    assign perf_d_grants = r_perf_d;
    assign perf_f_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a
// timestamp-based transaction model and a behavioural single-port memory.
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int MAXS = 3;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } dtx_t;

    logic        CLK = 1'b0;
    logic        rst, halt, f_req, d_req, d_we;
    logic [7:0]  f_addr, d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata;
    logic        f_ack, d_ack, mem_en, mem_we, idle;
    logic [15:0] f_rdata, d_rdata, mem_wdata;
    logic [7:0]  mem_addr;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [15:0] perf_f_grants, perf_d_grants, perf_f_stall;
    logic [15:0] m_pf, m_pd, m_stall;
`endif

    mem_port_arbiter dut (
        .CLK(CLK), .rst(rst), .halt(halt),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .idle(idle)
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .perf_f_grants(perf_f_grants), .perf_d_grants(perf_d_grants), .perf_f_stall(perf_f_stall)
`endif
    );

    always #5 CLK = ~CLK;

    // Single-port memory with a one-cycle registered read.
    logic [15:0] mem_arr [256];
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            mem_rdata <= mem_arr[mem_addr];
        end
    end

    // Reference model state: an access granted at edge n strobes the memory after edge n,
    // acks after edge n+LAT+1 and frees the arbiter for the edge n+LAT+3.
    logic [15:0] ref_mem [256];
    int          cyc, free_at, en_at, ack_at, streak;
    logic        g_d, g_we;
    logic [7:0]  g_addr;
    logic [15:0] g_data;
    logic        exp_mem_en, exp_f_ack, exp_d_ack, exp_idle, exp_mem_we;
    logic [7:0]  exp_mem_addr;
    logic [15:0] exp_mem_wdata, exp_f_rdata, exp_d_rdata;

    logic [7:0]  f_q[$];
    dtx_t        d_q[$];
    int          p_req;
    logic        order_log[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        free_at = 0; en_at = -100; ack_at = -100; streak = 0;
        g_d = 1'b0; g_we = 1'b0; g_addr = '0; g_data = '0;
        exp_mem_en = 1'b0; exp_f_ack = 1'b0; exp_d_ack = 1'b0; exp_idle = 1'b1;
        exp_mem_we = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0;
        exp_f_rdata = '0; exp_d_rdata = '0;
`ifdef MEM_PORT_ARBITER_PERF_EN
        m_pf = '0; m_pd = '0; m_stall = '0;
`endif
        f_q.delete(); d_q.delete();
        f_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic model_edge();
        logic fe, de, gnt;
        cyc++;
        if (rst !== 1'b1) return;
`ifdef MEM_PORT_ARBITER_PERF_EN
        if (f_req && !exp_f_ack && m_stall != 16'hFFFF) m_stall++;
`endif
        if (cyc == ack_at) begin
            if (!g_d) exp_f_rdata = g_data;
            else if (!g_we) exp_d_rdata = g_data;
        end
        if (cyc >= free_at) begin
            fe  = f_req && !halt;
            de  = d_req;
            gnt = 1'b0;
            if (de && !(fe && streak == MAXS)) begin
                gnt = 1'b1; g_d = 1'b1; g_we = d_we; g_addr = d_addr;
                exp_mem_wdata = d_wdata;
                streak = fe ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
`ifdef MEM_PORT_ARBITER_PERF_EN
                m_pd++;
`endif
            end else if (fe) begin
                gnt = 1'b1; g_d = 1'b0; g_we = 1'b0; g_addr = f_addr; streak = 0;
`ifdef MEM_PORT_ARBITER_PERF_EN
                m_pf++;
`endif
            end
            if (gnt) begin
                en_at = cyc; ack_at = cyc + LAT + 1; free_at = cyc + LAT + 3;
                g_data = ref_mem[g_addr];
                if (g_d && g_we) ref_mem[g_addr] = exp_mem_wdata;
                exp_mem_addr = g_addr;
                exp_mem_we   = g_d && g_we;
            end
        end
        exp_mem_en = (cyc == en_at);
        exp_f_ack  = (cyc == ack_at) && !g_d;
        exp_d_ack  = (cyc == ack_at) && g_d;
        exp_idle   = (cyc >= free_at - 1);
    endtask

    task automatic check_outputs();
        check("mem_en",   32'(mem_en),   32'(exp_mem_en));
        check("f_ack",    32'(f_ack),    32'(exp_f_ack));
        check("d_ack",    32'(d_ack),    32'(exp_d_ack));
        check("idle",     32'(idle),     32'(exp_idle));
        check("ack_excl", 32'(f_ack & d_ack), 32'(0));
        check("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
        check("f_rdata",  32'(f_rdata),  32'(exp_f_rdata));
        check("d_rdata",  32'(d_rdata),  32'(exp_d_rdata));
        if (exp_mem_en) check("mem_we", 32'(mem_we), 32'(exp_mem_we));
        if (exp_mem_en && exp_mem_we) check("mem_wdata", 32'(mem_wdata), 32'(exp_mem_wdata));
`ifdef MEM_PORT_ARBITER_PERF_EN
        check("perf_f_grants", 32'(perf_f_grants), 32'(m_pf));
        check("perf_d_grants", 32'(perf_d_grants), 32'(m_pd));
        check("perf_f_stall",  32'(perf_f_stall),  32'(m_stall));
`endif
        if (f_ack === 1'b1) order_log.push_back(1'b0);
        if (d_ack === 1'b1) order_log.push_back(1'b1);
    endtask

    task automatic present();
        if (!f_req && f_q.size() != 0 && $urandom_range(99) < 32'(p_req)) begin
            f_req = 1'b1; f_addr = f_q[0];
        end
        if (!d_req && d_q.size() != 0 && $urandom_range(99) < 32'(p_req)) begin
            d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
        end
    endtask

    task automatic drive();
        if (exp_f_ack) begin void'(f_q.pop_front()); f_req = 1'b0; f_addr = 8'($urandom); end
        if (exp_d_ack) begin void'(d_q.pop_front()); d_req = 1'b0; d_addr = 8'($urandom); end
        present();
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs();
        drive();
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((f_q.size() != 0 || d_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'(1));
    endtask

    initial begin
        logic        exp_order [8];
        dtx_t        t;
        int          n, en_seen;
`ifdef MEM_PORT_ARBITER_PERF_EN
        logic [15:0] pf0, pd0;
`endif
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b0; halt = 1'b0; d_we = 1'b0; f_addr = '0; d_addr = '0; d_wdata = '0;
        cyc = 0; p_req = 100;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 16'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[1] = 16'h8107; ref_mem[1] = 16'h8107;
        mem_arr[2] = 16'h8205; ref_mem[2] = 16'h8205;
        model_reset();

        // Reset state.
        repeat (2) @(negedge CLK);
        check_outputs();
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        check("rst_mem_we",    32'(mem_we),    32'(0));
        rst = 1'b1;

        // Single fetch.
        f_q.push_back(8'h01); present();
        drain(50);
        check("t1_f_rdata", 32'(f_rdata), 32'(16'h8107));

        // Data write then read back.
        t = '{we: 1'b1, addr: 8'h05, wdata: 16'h000C};
        d_q.push_back(t); present();
        drain(50);
        check("t2_mem5", 32'(mem_arr[5]), 32'(16'h000C));
        check("t2_d_rdata_kept", 32'(d_rdata), 32'(0));
        t = '{we: 1'b0, addr: 8'h05, wdata: 16'hDEAD};
        d_q.push_back(t); present();
        drain(50);
        check("t2_d_rdata", 32'(d_rdata), 32'(16'h000C));

        // Contention and the data streak cap.
        order_log.delete();
`ifdef MEM_PORT_ARBITER_PERF_EN
        pf0 = m_pf; pd0 = m_pd;
`endif
        for (int i = 0; i < 6; i++) begin
            t = '{we: 1'(i % 2), addr: 8'(8'h20 + i), wdata: 16'(16'h1000 + i)};
            d_q.push_back(t);
        end
        f_q.push_back(8'h10); f_q.push_back(8'h11);
        present();
        drain(200);
        for (int i = 0; i < 8; i++)
            check($sformatf("t3_order_%0d", i),
                  (i < order_log.size()) ? 32'(order_log[i]) : 32'd2, 32'(exp_order[i]));
`ifdef MEM_PORT_ARBITER_PERF_EN
        check("t6_perf_d", 32'(perf_d_grants), 32'(pd0 + 16'd6));
        check("t6_perf_f", 32'(perf_f_grants), 32'(pf0 + 16'd2));
        check("t6_perf_stall_nz", 32'(perf_f_stall != 0), 32'(1));
`endif

        // Halt blocks new fetches but not data.
        halt = 1'b1;
        f_q.push_back(8'h02); present();
        en_seen = 0;
        repeat (20) begin
            cycle();
            if (mem_en === 1'b1) en_seen++;
        end
        check("t4_no_mem_en", 32'(en_seen), 32'(0));
        check("t4_idle", 32'(idle), 32'(1));
        t = '{we: 1'b0, addr: 8'h01, wdata: 16'h0};
        d_q.push_back(t); present();
        n = 0;
        while (d_q.size() != 0 && n < 50) begin cycle(); n++; end
        check("t4_d_timeout", 32'(n < 50), 32'(1));
        check("t4_d_rdata", 32'(d_rdata), 32'(16'h8107));
        halt = 1'b0;
        drain(50);

        // Reset in the middle of a fetch aborts it.
        f_q.push_back(8'h01); present();
        n = 0;
        while (!exp_mem_en && n < 50) begin cycle(); n++; end
        check("t5_issue_timeout", 32'(n < 50), 32'(1));
        cycle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("t5_mem_wdata", 32'(mem_wdata), 32'(0));
        check("t5_mem_we",    32'(mem_we),    32'(0));
        @(posedge CLK); model_edge();
        @(negedge CLK); check_outputs();
        rst = 1'b1;
        f_q.push_back(8'h02); present();
        drain(50);
        check("t5_f_rdata", 32'(f_rdata), 32'(16'h8205));

        // Random traffic with halt toggling.
        p_req = 40;
        repeat (400) begin
            if ($urandom_range(5) == 0 && f_q.size() < 3) f_q.push_back(8'($urandom_range(15)));
            if ($urandom_range(4) == 0 && d_q.size() < 3) begin
                t = '{we: 1'($urandom_range(1)), addr: 8'($urandom_range(15)), wdata: 16'($urandom)};
                d_q.push_back(t);
            end
            if ($urandom_range(7) == 0) halt = ~halt;
            cycle();
        end
        halt = 1'b0; p_req = 100;
        drain(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
